wb_dest_pipe: RTL and testbench
===============================

WB_DEST_PIPE -- requirements
Module: wb_dest_pipe

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, the register address width.
REQ-002 The block SHALL have parameter NREG, default 32 (2**ADDR_W), the one-hot write-enable width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port ex_dest  input  ADDR_W  the EX-stage destination register, i.e. the RegDst select result.
REQ-006 The block SHALL have port ex_wr  input  1  the EX-stage register-write request.
REQ-007 The block SHALL have port stall  input  1  a request to hold both pipeline stages.
REQ-008 The block SHALL have port flush  input  1  a request to insert a bubble into the MEM stage.
REQ-009 The block SHALL have ports mem_dest (output, ADDR_W) and mem_wr (output, 1), carrying the registered MEM-stage destination.
REQ-010 The block SHALL have ports wb_dest (output, ADDR_W) and wb_wr (output, 1), carrying the registered WB-stage destination.
REQ-011 The block SHALL have port wb_we  output  NREG  the one-hot register-file write enable.
REQ-012 Under WB_DEST_FWD_EN only, the block SHALL have inputs ex_rs and ex_rt (each ADDR_W) and outputs fwd_a and fwd_b (each 2 bits).

Function
REQ-013 On each rising edge with rst=0, stall=0 and flush=0:
- mem_dest/mem_wr SHALL capture ex_dest/ex_wr.
- wb_dest/wb_wr SHALL capture mem_dest/mem_wr.
REQ-014 When ex_dest equals 0, mem_wr SHALL be captured as 0, because writes to $0 are suppressed; mem_dest SHALL still capture 0.
REQ-015 With stall=1 and flush=0, both stages SHALL hold their values.
REQ-016 With flush=1, regardless of stall:
- mem_wr and mem_dest SHALL be cleared to 0.
- The WB stage SHALL load from MEM if stall=0 and hold if stall=1.
REQ-017 wb_we SHALL be combinational from the WB stage: bit wb_dest set when wb_wr=1, all zeros otherwise; it SHALL never have more than one bit set.
REQ-018 The latency from ex_dest/ex_wr to wb_we SHALL be exactly 2 unstalled cycles.
REQ-019 All outputs SHALL depend only on registered state, plus ex_rs/ex_rt for forwarding; there SHALL be no path from ex_dest to any output.

Reset
REQ-020 While rst=1 at a clock edge, mem_dest, mem_wr, wb_dest and wb_wr SHALL clear to 0; consequently wb_we is 0 and fwd_a/fwd_b are 00.
REQ-021 rst SHALL take priority over stall and flush; an in-flight write present at reset SHALL be discarded and never appear on wb_we.

Configuration
REQ-022 Macro WB_DEST_FWD_EN defined: fwd_a SHALL be computed combinationally from ex_rs as follows.
- 10 when mem_wr=1 and mem_dest==ex_rs.
- Otherwise 01 when wb_wr=1 and wb_dest==ex_rs.
- Otherwise 00.
- fwd_b SHALL be computed identically from ex_rt.
- The MEM match SHALL win when both stages match.
REQ-023 Macro WB_DEST_FWD_EN undefined: the ex_rs, ex_rt, fwd_a and fwd_b ports and the compare logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-024 A shared package SHALL hold ADDR_W_DEF=5 and the forwarding encodings FWD_NONE=00, FWD_WB=01 and FWD_MEM=10.
REQ-025 The one-hot decode SHALL be a sub-module dest_decoder (inputs: ADDR_W address and enable; output: NREG one-hot vector), instantiated once.

Verification
REQ-026 Reset: hold rst=1 for 2 cycles with ex_wr=1, ex_dest=7 -> all outputs 0; release rst, ex_dest=7, ex_wr=1 -> wb_we=0x00000080 two edges later.
REQ-027 $0 suppression: ex_dest=0, ex_wr=1 -> mem_wr=0 next cycle, then wb_wr=0 and wb_we=0.
REQ-028 Stall: ex_dest=5, ex_wr=1, then stall=1 for 3 cycles -> mem_dest=5 and mem_wr=1 held; wb_we unchanged throughout.
REQ-029 Flush/stall collision: with mem_dest=9, mem_wr=1 and wb_dest=3, wb_wr=1, drive flush=1, stall=1 -> mem_wr=0 and mem_dest=0; wb_dest=3, wb_we=0x00000008 held.
REQ-030 Forwarding (WB_DEST_FWD_EN defined): with mem_dest=4, mem_wr=1 and wb_dest=4, wb_wr=1, drive ex_rs=4 -> fwd_a=10; with ex_rt=4 after mem_wr clears -> fwd_b=01; with ex_rs=6 -> fwd_a=00.

Source files
------------

// File: rtl/wb_dest_pipe_pkg.sv
// Shared constants and forwarding encodings for the write-back destination pipeline.
package wb_dest_pipe_pkg;

  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_e;

  // The younger MEM-stage result wins when both stages target the same register.
  function automatic fwd_e fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else return FWD_NONE;
  endfunction

endpackage

// File: rtl/wb_dest_pipe_decoder.sv
// dest_decoder: address plus enable to a one-hot register-file write enable.
module dest_decoder #(
  parameter int ADDR_W = 5,
  parameter int NREG   = 2**ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [NREG-1:0]   onehot
);

  always_comb begin
    // NOTE: default first so every path assigns onehot and no latch is inferred.
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/wb_dest_pipe.sv
// MEM/WB destination-register pipeline with stall, flush, $0 suppression and one-hot write enable.
// Optional operand forwarding compare is enabled by defining WB_DEST_FWD_EN.
module wb_dest_pipe
  import wb_dest_pipe_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREG   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ex_dest,
  input  logic              ex_wr,
  input  logic              stall,
  input  logic              flush,
`ifdef WB_DEST_FWD_EN
  input  logic [ADDR_W-1:0] ex_rs,
  input  logic [ADDR_W-1:0] ex_rt,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
`endif
  output logic [ADDR_W-1:0] mem_dest,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] wb_dest,
  output logic              wb_wr,
  output logic [NREG-1:0]   wb_we
);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so WB samples the old MEM value on the same edge MEM updates.
    if (rst) begin
      mem_dest <= '0;
      mem_wr   <= 1'b0;
      wb_dest  <= '0;
      wb_wr    <= 1'b0;
    end else begin
      if (flush) begin
        mem_dest <= '0;
        mem_wr   <= 1'b0;
      end else if (!stall) begin
        mem_dest <= ex_dest;
        // Writes to $0 are dropped here so they never reach the register file.
        mem_wr   <= ex_wr && (ex_dest != '0);
      end
      if (!stall) begin
        wb_dest <= mem_dest;
        wb_wr   <= mem_wr;
      end
    end
  end

  dest_decoder #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_dest_decoder (
    .addr   (wb_dest),
    .en     (wb_wr),
    .onehot (wb_we)
  );

`ifdef WB_DEST_FWD_EN
  assign fwd_a = fwd_sel(mem_wr && (mem_dest == ex_rs), wb_wr && (wb_dest == ex_rs));
  assign fwd_b = fwd_sel(mem_wr && (mem_dest == ex_rt), wb_wr && (wb_dest == ex_rt));
`endif

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Self-checking bench for wb_dest_pipe: directed reset/stall/flush cases plus a scoreboarded random stream.
`timescale 1ns/1ps
module tb_wb_dest_pipe;

  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] ex_dest;
  logic              ex_wr;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] mem_dest;
  logic              mem_wr;
  logic [ADDR_W-1:0] wb_dest;
  logic              wb_wr;
  logic [NREG-1:0]   wb_we;
`ifdef WB_DEST_FWD_EN
  logic [ADDR_W-1:0] ex_rs;
  logic [ADDR_W-1:0] ex_rt;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
`endif

  int checks   = 0;
  int failures = 0;
  logic [NREG-1:0] exp_q[$];

  always #5 clk = ~clk;

  wb_dest_pipe #(.ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .clk      (clk),
    .rst      (rst),
    .ex_dest  (ex_dest),
    .ex_wr    (ex_wr),
    .stall    (stall),
    .flush    (flush),
`ifdef WB_DEST_FWD_EN
    .ex_rs    (ex_rs),
    .ex_rt    (ex_rt),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b),
`endif
    .mem_dest (mem_dest),
    .mem_wr   (mem_wr),
    .wb_dest  (wb_dest),
    .wb_wr    (wb_wr),
    .wb_we    (wb_we)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NREG-1:0] onehot(input int dest, input logic wr);
    logic [NREG-1:0] v;
    v = '0;
    if (wr && dest != 0) v[dest] = 1'b1;
    return v;
  endfunction

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    ex_dest = 5'd7; ex_wr = 1'b1;
`ifdef WB_DEST_FWD_EN
    ex_rs = '0; ex_rt = '0;
`endif
    @(negedge clk);

    // Reset held two cycles with a pending write present.
    tick(); tick();
    check("rst_mem_dest", mem_dest, 0);
    check("rst_mem_wr",   mem_wr,   0);
    check("rst_wb_dest",  wb_dest,  0);
    check("rst_wb_wr",    wb_wr,    0);
    check("rst_wb_we",    wb_we,    0);
`ifdef WB_DEST_FWD_EN
    check("rst_fwd_a", fwd_a, 0);
    check("rst_fwd_b", fwd_b, 0);
`endif

    // Release reset: write to r7 appears on wb_we two edges later.
    rst = 1'b0;
    tick();
    check("lat_mem_dest", mem_dest, 7);
    check("lat_wb_we_1",  wb_we,    0);
    ex_wr = 1'b0; ex_dest = '0;
    tick();
    check("lat_wb_we_2", wb_we, 64'h80);

    // $0 suppression.
    ex_dest = '0; ex_wr = 1'b1;
    tick();
    check("zero_mem_wr",   mem_wr,   0);
    check("zero_mem_dest", mem_dest, 0);
    ex_wr = 1'b0;
    tick();
    check("zero_wb_wr", wb_wr, 0);
    check("zero_wb_we", wb_we, 0);

    // Stall holds both stages; EX changes meanwhile must not leak in.
    ex_dest = 5'd5; ex_wr = 1'b1;
    tick();
    stall = 1'b1; ex_dest = 5'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_mem_dest_%0d", i), mem_dest, 5);
      check($sformatf("stall_mem_wr_%0d", i),   mem_wr,   1);
      check($sformatf("stall_wb_we_%0d", i),    wb_we,    0);
    end
    stall = 1'b0;

    // Flush/stall collision: MEM cleared, WB held.
    ex_dest = 5'd3; ex_wr = 1'b1;
    tick();
    ex_dest = 5'd9;
    tick();
    check("pre_col_mem_dest", mem_dest, 9);
    check("pre_col_wb_we",    wb_we,    64'h8);
    flush = 1'b1; stall = 1'b1;
    tick();
    check("col_mem_wr",   mem_wr,   0);
    check("col_mem_dest", mem_dest, 0);
    check("col_wb_dest",  wb_dest,  3);
    check("col_wb_we",    wb_we,    64'h8);

    // Flush alone: MEM cleared while WB advances.
    flush = 1'b0; stall = 1'b0; ex_dest = 5'd12;
    tick();
    check("bubble_wb_we", wb_we, 0);
    flush = 1'b1;
    tick();
    check("flush_mem_wr", mem_wr, 0);
    check("flush_wb_we",  wb_we,  64'h1000);
    flush = 1'b0;

    // Reset beats stall/flush and discards the in-flight write.
    ex_dest = 5'd20; ex_wr = 1'b1;
    tick();
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    tick();
    check("rst_prio_mem_wr", mem_wr, 0);
    check("rst_prio_wb_wr",  wb_wr,  0);
    rst = 1'b0; stall = 1'b0; flush = 1'b0; ex_wr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("rst_discard_%0d", i), wb_we, 0);
    end

`ifdef WB_DEST_FWD_EN
    // Forwarding priority: MEM over WB.
    ex_dest = 5'd4; ex_wr = 1'b1;
    tick(); tick();
    ex_rs = 5'd4;
    #1 check("fwd_a_mem", fwd_a, 2'b10);
    ex_wr = 1'b0;
    tick();
    ex_rt = 5'd4;
    #1 check("fwd_b_wb", fwd_b, 2'b01);
    ex_rs = 5'd6;
    #1 check("fwd_a_none", fwd_a, 2'b00);
`endif

    // Scoreboarded random unstalled stream: expected wb_we pushed on drive, popped two edges later.
    for (int i = 0; i < 64; i++) begin
      ex_dest = ADDR_W'($urandom_range(0, NREG - 1));
      ex_wr   = 1'($urandom_range(0, 1));
      exp_q.push_back(onehot(int'(ex_dest), ex_wr));
      tick();
      if (exp_q.size() == 2) check($sformatf("sb_%0d", i), wb_we, exp_q.pop_front());
    end
    ex_wr = 1'b0;
    while (exp_q.size() > 0) begin
      tick();
      check("sb_drain", wb_we, exp_q.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
